// File: rtl/sysbus_memory.sv
// Sysbus 64-bit word memory slave: ALE latches address, Ready rises WAIT_STATES edges after strobe.
// Four-phase handshake: Ready/read data held until the strobe is released; early release aborts.
module sysbus_memory #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clock,
  input  logic        nReset,
  inout  wire  [63:0] Sysbus,
  input  logic        ALE,
  input  logic        nOE,
  input  logic        nWE,
  output logic        Ready,
  output logic        BusError
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_WAIT, ST_RESP} state_t;

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t                  state, state_nxt;
  logic [63:0]             addr;
  logic [63:0]             rdata;
  logic [3:0]              cnt;
  logic                    dir_rd;
  logic                    err;
  logic [63:0]             mem [DEPTH];

  logic                    strobe_any, strobe_both, strobe_released;
  logic                    range_err, enter_resp, acc_rd, acc_err;
  logic                    bus_drive, mem_we;
  logic [ADDR_WIDTH-1:0]   idx;

  assign strobe_any      = !nOE || !nWE;
  assign strobe_both     = !nOE && !nWE;
  assign strobe_released = dir_rd ? nOE : nWE;
  assign range_err       = |addr[63:ADDR_WIDTH];
  assign idx             = addr[ADDR_WIDTH-1:0];
  // In ARMED the direction is not yet registered, so take it from the live strobes.
  assign acc_rd          = (state == ST_ARMED) ? (!nOE && nWE) : dir_rd;
  assign acc_err         = range_err || (state == ST_ARMED && strobe_both);

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state  <= ST_IDLE;
      addr   <= '0;
      cnt    <= '0;
      dir_rd <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
      Ready  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ALE && (state == ST_IDLE || state == ST_ARMED))
        addr <= Sysbus;
      if (state == ST_ARMED && !ALE && strobe_any) begin
        dir_rd <= !nOE && nWE;
        cnt    <= CNT_INIT;
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        Ready <= 1'b1;
        err   <= acc_err;
        rdata <= (acc_rd && !acc_err) ? mem[idx] : '0;
      end else if (state == ST_RESP && state_nxt == ST_IDLE) begin
        Ready <= 1'b0;
        err   <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    enter_resp = 1'b0;
    unique case (state)
      ST_IDLE: if (ALE) state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (!ALE && strobe_any) begin
          // An illegal strobe pair skips the wait and reports an error at once.
          if (strobe_both || WAIT_STATES == 0) begin
            state_nxt  = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (ALE || strobe_released) begin
          state_nxt = ST_IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt  = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: if (strobe_released) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_drive = (state == ST_RESP) && dir_rd;
    mem_we    = enter_resp && nReset && !acc_rd && !acc_err;
  end

  assign Sysbus   = bus_drive ? rdata : 'z;
  assign BusError = err;

  always_ff @(posedge Clock) begin
    if (mem_we)
      mem[idx] <= Sysbus;
  end

endmodule

// File: tb/tb_sysbus_memory.sv
// Bench for sysbus_memory: three instances (2, 0 and 3 wait states) against an array reference model.
module tb_sysbus_memory;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic [2:0]  ale = 3'b000;
  logic [2:0]  noe = 3'b111;
  logic [2:0]  nwe = 3'b111;
  logic [2:0]  rdy, berr;
  logic [2:0]  drv_en = 3'b111;
  logic [63:0] drv [3];
  wire  [63:0] bus0, bus1, bus2;

  logic [63:0] mdl [3][256];
  int          checks = 0;
  int          failures = 0;

  always #5 Clock = ~Clock;

  assign bus0 = drv_en[0] ? drv[0] : 'z;
  assign bus1 = drv_en[1] ? drv[1] : 'z;
  assign bus2 = drv_en[2] ? drv[2] : 'z;

  sysbus_memory #(.ADDR_WIDTH(8), .WAIT_STATES(2)) u_ws2 (
    .Clock(Clock), .nReset(nReset), .Sysbus(bus0), .ALE(ale[0]), .nOE(noe[0]), .nWE(nwe[0]),
    .Ready(rdy[0]), .BusError(berr[0]));
  sysbus_memory #(.ADDR_WIDTH(8), .WAIT_STATES(0)) u_ws0 (
    .Clock(Clock), .nReset(nReset), .Sysbus(bus1), .ALE(ale[1]), .nOE(noe[1]), .nWE(nwe[1]),
    .Ready(rdy[1]), .BusError(berr[1]));
  sysbus_memory #(.ADDR_WIDTH(8), .WAIT_STATES(3)) u_ws3 (
    .Clock(Clock), .nReset(nReset), .Sysbus(bus2), .ALE(ale[2]), .nOE(noe[2]), .nWE(nwe[2]),
    .Ready(rdy[2]), .BusError(berr[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] busv(input int k);
    case (k)
      0:       return bus0;
      1:       return bus1;
      default: return bus2;
    endcase
  endfunction

  function automatic int wsof(input int k);
    case (k)
      0:       return 2;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  // op: 0 read, 1 write, 2 both strobes low, 3 write aborted after one strobe cycle
  task automatic txn(input int k, input logic [63:0] a, input int op, input logic [63:0] d);
    int          ws  = wsof(k);
    logic        oor = |a[63:8];
    logic        rd  = (op == 0);
    logic [63:0] exp;
    int          lat = -1;
    @(posedge Clock); #1;
    ale[k] = 1'b1; drv_en[k] = 1'b1; drv[k] = a;
    @(posedge Clock); #1;
    ale[k] = 1'b0;
    case (op)
      0:       begin drv_en[k] = 1'b0; noe[k] = 1'b0; end
      2:       begin drv[k] = '0; noe[k] = 1'b0; nwe[k] = 1'b0; end
      default: begin drv[k] = d; nwe[k] = 1'b0; end
    endcase
    if (op == 3) begin
      @(posedge Clock); #1;
      nwe[k] = 1'b1; drv[k] = '0;
      for (int i = 0; i < ws + 3; i++) begin
        @(negedge Clock);
        chk("abort_ready", 64'(rdy[k]), 64'd0);
      end
      return;
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge Clock); @(negedge Clock);
      if (rdy[k]) begin lat = i; break; end
    end
    chk("latency", 64'(lat), 64'((op == 2) ? 0 : ws));
    chk("buserror", 64'(berr[k]), 64'((op == 2) || oor));
    exp = oor ? 64'd0 : mdl[k][a[7:0]];
    if (rd) begin
      chk("rdata", busv(k), exp);
    end else begin
      drv[k] = '0; #1;
      chk("hiz_resp", busv(k), 64'd0);
    end
    if (op == 1 && !oor) mdl[k][a[7:0]] = d;
    @(posedge Clock); @(negedge Clock);
    chk("ready_hold", 64'(rdy[k]), 64'd1);
    if (rd) chk("rdata_hold", busv(k), exp);
    noe[k] = 1'b1; nwe[k] = 1'b1;
    @(posedge Clock); #1;
    drv_en[k] = 1'b1; drv[k] = '0;
    @(negedge Clock);
    chk("rel_ready", 64'(rdy[k]), 64'd0);
    chk("rel_buserror", 64'(berr[k]), 64'd0);
    chk("rel_hiz", busv(k), 64'd0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) drv[k] = '0;

    // Reset held with ALE/nOE toggling
    for (int c = 0; c < 3; c++) begin
      @(posedge Clock); #1;
      ale = ~ale; noe = ~noe;
      @(negedge Clock);
      for (int k = 0; k < 3; k++) begin
        chk("rst_ready", 64'(rdy[k]), 64'd0);
        chk("rst_buserror", 64'(berr[k]), 64'd0);
        chk("rst_hiz", busv(k), 64'd0);
      end
    end
    ale = 3'b000; noe = 3'b111; nReset = 1'b1;

    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 16; a++)
        txn(k, 64'(a), 1, {$urandom, $urandom});

    txn(0, 64'h05, 1, 64'hDEAD_BEEF_0123_4567);
    txn(0, 64'h05, 0, '0);
    txn(1, 64'hFF, 1, 64'h1);
    txn(1, 64'hFF, 0, '0);
    txn(0, 64'h100, 1, 64'hAA);
    txn(0, 64'h00, 0, '0);
    txn(0, 64'h100, 0, '0);
    txn(2, 64'h10, 1, 64'h1234_5678);
    txn(2, 64'h10, 3, 64'h77);
    txn(2, 64'h10, 0, '0);
    txn(0, 64'h05, 2, '0);
    txn(0, 64'h05, 0, '0);

    // Reset landing on the RESP entry edge drops the write
    @(posedge Clock); #1;
    ale[0] = 1'b1; drv[0] = 64'h3;
    @(posedge Clock); #1;
    ale[0] = 1'b0; drv[0] = 64'h5555_AAAA_5555_AAAA; nwe[0] = 1'b0;
    @(posedge Clock);
    @(posedge Clock); #1;
    nReset = 1'b0;
    @(posedge Clock); #1;
    nReset = 1'b1; nwe[0] = 1'b1; drv[0] = '0;
    @(negedge Clock);
    chk("rst_entry_ready", 64'(rdy[0]), 64'd0);
    txn(0, 64'h3, 0, '0);

    // Reset while a read is in RESP releases Ready and the bus
    @(posedge Clock); #1;
    ale[0] = 1'b1; drv[0] = 64'h5;
    @(posedge Clock); #1;
    ale[0] = 1'b0; drv_en[0] = 1'b0; noe[0] = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("resp_ready", 64'(rdy[0]), 64'd1);
    chk("resp_rdata", bus0, mdl[0][5]);
    nReset = 1'b0;
    @(posedge Clock); #1;
    nReset = 1'b1; noe[0] = 1'b1; drv_en[0] = 1'b1; drv[0] = '0;
    @(negedge Clock);
    chk("rst_resp_ready", 64'(rdy[0]), 64'd0);
    chk("rst_resp_buserror", 64'(berr[0]), 64'd0);
    chk("rst_resp_hiz", bus0, 64'd0);

    for (int n = 0; n < 60; n++) begin
      int          k  = $urandom_range(0, 2);
      int          op = $urandom_range(0, 3);
      logic [63:0] a  = 64'($urandom_range(0, 15));
      if (op == 3 && k == 1) op = 1;
      if ($urandom_range(0, 5) == 0) a = a | (64'h1 << $urandom_range(8, 63));
      txn(k, a, op, {$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sysbus_memory.md
# sysbus_memory

Word-addressed 64-bit memory responder on the shared tri-state Sysbus, serving the single-core datapath's address (PC), write-data (Rs2) and read-data (DR) transfers. The block latches an address phase, inserts a programmable number of wait states, and then completes a read or write with a four-phase Ready handshake. It is the slave end of the bus the datapath masters through TrisPC/TrisRs2/LoadDR.

## Interface
- ADDR_WIDTH, 8: word-address bits implemented; depth 2^ADDR_WIDTH 64-bit words.
- WAIT_STATES, 2: cycles between strobe sample and Ready; legal 0..15.
- Clock  input  1  rising-edge clock.
- nReset  input  1  reset, synchronous, active-low.
- Sysbus  inout  64  shared bus; address during ALE, write data while nWE low, read data driven by this block in RESP.
- ALE  input  1  address latch enable, high one or more cycles with address on Sysbus.
- nOE  input  1  read strobe, active-low.
- nWE  input  1  write strobe, active-low.
- Ready  output  1  transfer complete, registered.
- BusError  output  1  out-of-range address or illegal strobe combination; valid while Ready=1.

## Operation
- States: IDLE, ARMED, WAIT, RESP. Registers: addr (64b latched), cnt (4b), rdata (64b), dir (read/write), err.
- IDLE: ALE=1 -> latch addr <= Sysbus, go ARMED. Strobes ignored.
- ARMED: ALE=1 -> relatch addr, stay ARMED (ALE has priority over strobes). Else exactly one strobe low -> record dir; WAIT_STATES=0 -> RESP, else WAIT with cnt=WAIT_STATES-1... cnt=0 -> RESP next edge. Both strobes low -> RESP with err=1, no memory access.
- WAIT: strobe of recorded dir released or ALE=1 -> IDLE (abort; no write, no Ready). cnt==0 -> RESP; else cnt decrements.
- Range: addr[63:ADDR_WIDTH] nonzero -> err=1; write suppressed; rdata=0.
- On entry edge to RESP: write -> mem[addr[ADDR_WIDTH-1:0]] <= Sysbus sampled at that edge (unless err); read -> rdata <= mem[...] (or 0 if err). Ready<=1, BusError<=err.
- RESP: Sysbus driven with rdata iff dir=read; otherwise high-Z. Stay while the recorded strobe is low. Strobe sampled high -> IDLE, Ready<=0, BusError<=0, Sysbus released same edge.
- Sysbus is high-Z in every state except RESP-read; never driven during ALE.
- Memory contents are not reset; state is.

## Timing
- Reset (nReset=0 at edge): state IDLE, Ready=0, BusError=0, Sysbus high-Z, cnt=0, err=0. Applies mid-transaction: pending write is dropped if reset coincides with the RESP entry edge.
- Strobe first sampled low at edge N (state ARMED) -> Ready=1 after edge N+WAIT_STATES; WAIT_STATES=0 gives Ready after edge N.
- Read data valid on Sysbus in the same cycle Ready rises; held stable until strobe release.
- Write data must be stable at edge N+WAIT_STATES; later changes ignored.
- Strobe release sampled at edge M -> Ready=0 and bus high-Z after edge M. Next ALE accepted at edge M+1 (IDLE).
- Back-to-back: one cycle minimum between Ready falling and next ALE.
- Strobe low in IDLE (no ALE) is ignored until ALE.

## Test plan
- Reset: hold nReset=0 3 cycles with ALE/nOE toggling -> Ready=0, BusError=0, Sysbus high-Z throughout.
- Write/read, WAIT_STATES=2: ALE addr 0x05; nWE low with 0xDEAD_BEEF_0123_4567 -> Ready after 2 edges, BusError=0; release; ALE 0x05, nOE low -> Ready after 2 edges, Sysbus=0xDEAD_BEEF_0123_4567.
- WAIT_STATES=0: write 0x1 to addr 0xFF then read -> Ready on strobe edge, data 0x1; addr 0xFF boundary word correct.
- Out of range: ALE addr 0x100 (ADDR_WIDTH=8), nWE low data 0xAA -> Ready=1, BusError=1; read of 0x00 returns prior contents, read of 0x100 returns 0 with BusError=1.
- Abort: ALE addr 0x10, nWE low with 0x77, release after 1 cycle (WAIT_STATES=3) -> no Ready; read 0x10 returns old value.
- Both strobes low in ARMED -> Ready=1, BusError=1, Sysbus high-Z, memory unchanged; reset asserted in RESP -> Ready=0 and bus released after that edge.
